// File: rtl/sha_core_arbiter.sv
// rtl/sha_core_arbiter.sv - round-robin arbiter sharing one SHA-256 core among 4 requesters
// Optional watchdog abort of a hung core is built when SHA_ARB_WATCHDOG_EN is defined.
module sha_core_arbiter #(
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 11
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       core_done,
   output logic [1:0] sel,
   output logic [3:0] gnt,
   output logic       core_start,
   output logic [3:0] ack,
   output logic       busy,
   output logic       timeout_err
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

   state_t     r_state;
   logic [1:0] r_ptr;
   logic [1:0] r_sel;
   logic [3:0] r_gnt;
   logic [3:0] r_ack;
   logic       r_core_start;
   logic       r_busy;
   logic [1:0] w_winner;

   if (2**CNT_W <= TIMEOUT) begin : g_bad_cfg
      $error("CNT_W too narrow for TIMEOUT");
   end

   // First requester found scanning ptr+1, ptr+2, ptr+3, ptr.
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] idx;
      rr_pick = p;
      for (int k = 4; k >= 1; k--) begin
         idx = p + 2'(k);
         if (r[idx]) rr_pick = idx;
      end
   endfunction

   assign w_winner = rr_pick(req, r_ptr);

`ifdef SHA_ARB_WATCHDOG_EN
   logic [CNT_W-1:0] r_cnt;
   logic             r_timeout_err;
   assign timeout_err = r_timeout_err;
`else
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_ptr        <= 2'd3;
         r_sel        <= 2'd0;
         r_gnt        <= 4'd0;
         r_ack        <= 4'd0;
         r_core_start <= 1'b0;
         r_busy       <= 1'b0;
`ifdef SHA_ARB_WATCHDOG_EN
         r_cnt         <= '0;
         r_timeout_err <= 1'b0;
`endif
      end else begin
         r_core_start <= 1'b0;
         r_ack        <= 4'd0;
`ifdef SHA_ARB_WATCHDOG_EN
         r_timeout_err <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (|req) begin
                  r_gnt        <= 4'b0001 << w_winner;
                  r_sel        <= w_winner;
                  r_core_start <= 1'b1;
                  r_busy       <= 1'b1;
                  r_state      <= S_START;
               end
            end
            S_START: begin
`ifdef SHA_ARB_WATCHDOG_EN
               r_cnt <= '0;
`endif
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (core_done) begin
                  r_ack   <= r_gnt;
                  r_gnt   <= 4'd0;
                  r_busy  <= 1'b0;
                  r_ptr   <= r_sel;
                  r_state <= S_IDLE;
               end
`ifdef SHA_ARB_WATCHDOG_EN
               // Abort also advances ptr so the hung requester goes to the back.
               else if (r_cnt == CNT_W'(TIMEOUT)) begin
                  r_timeout_err <= 1'b1;
                  r_gnt         <= 4'd0;
                  r_busy        <= 1'b0;
                  r_ptr         <= r_sel;
                  r_state       <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
`endif
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign sel        = r_sel;
   assign gnt        = r_gnt;
   assign core_start = r_core_start;
   assign ack        = r_ack;
   assign busy       = r_busy;

endmodule
